// File: rtl/rgb_cmd_fifo_if.sv
// Command handshake between the colour FIFO and the MTL draw engine.
// The master presents the head command and the slave accepts it with ready.
interface rgb_cmd_fifo_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_img;
    logic [23:0] cmd_rgb;

    modport master (output cmd_valid, output cmd_img, output cmd_rgb, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_img, input cmd_rgb, output cmd_ready);
endinterface

// File: rtl/rgb_cmd_fifo.sv
// Buffers {ImgNum, Red, Green, Blue} commands captured on Trigger and hands them
// to the draw engine; reports fill level and sticky overflow as a status byte.
module rgb_cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             theClock,
    input  logic             theReset_n,
    input  logic [7:0]       Red,
    input  logic [7:0]       Green,
    input  logic [7:0]       Blue,
    input  logic [7:0]       ImgNum,
    input  logic             Trigger,
    input  logic             Clear,
    rgb_cmd_fifo_if.master   cmd,
    output logic [AW:0]      level,
    output logic [7:0]       Status
);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [AW:0]   level_n;
    logic          overflow, overflow_n;
    logic          pop, push_ok, full;
    logic [7:0]    status_n;
    logic [3:0]    level_sat;

    assign full          = (level == (AW+1)'(DEPTH));
    assign pop           = (level != '0) && cmd.cmd_ready;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign push_ok       = Trigger && (!full || pop);

    assign cmd.cmd_valid = (level != '0);
    assign cmd.cmd_img   = mem[rd_ptr][31:24];
    assign cmd.cmd_rgb   = mem[rd_ptr][23:0];

    always_comb begin
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        level_n    = level;
        overflow_n = overflow;
        if (Clear) begin
            wr_ptr_n   = '0;
            rd_ptr_n   = '0;
            level_n    = '0;
            overflow_n = 1'b0;
        end else begin
            if (push_ok) wr_ptr_n = wr_ptr + 1'b1;
            if (pop)     rd_ptr_n = rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   level_n = level + 1'b1;
                2'b01:   level_n = level - 1'b1;
                default: level_n = level;
            endcase
            if (Trigger && !push_ok) overflow_n = 1'b1;
        end
    end

    // status is built from next-state values so it lines up with level
    always_comb begin
        level_sat = (int'(level_n) > 15) ? 4'hF : 4'(level_n);
        status_n  = {level_sat,
                     (int'(level_n) >= DEPTH/2),
                     overflow_n,
                     (level_n == (AW+1)'(DEPTH)),
                     (level_n == '0)};
    end

    always_ff @(posedge theClock or negedge theReset_n) begin
        if (!theReset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            Status   <= 8'h01;
        end else begin
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            level    <= level_n;
            overflow <= overflow_n;
            Status   <= status_n;
        end
    end

    always_ff @(posedge theClock) begin
        if (push_ok && !Clear) mem[wr_ptr] <= {ImgNum, Red, Green, Blue};
    end

endmodule

// File: tb/tb_rgb_cmd_fifo.sv
// Randomised and directed bench for rgb_cmd_fifo: a queue-based reference model
// tracks accepted commands; a negedge monitor compares head, level and status.
module tb_rgb_cmd_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  red = '0, green = '0, blue = '0, img = '0;
    logic        trig = 1'b0, clr = 1'b0;
    logic [AW:0] level;
    logic [7:0]  status;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    rgb_cmd_fifo_if cif();

    rgb_cmd_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .theClock  (clk),
        .theReset_n(rst_n),
        .Red       (red),
        .Green     (green),
        .Blue      (blue),
        .ImgNum    (img),
        .Trigger   (trig),
        .Clear     (clr),
        .cmd       (cif.master),
        .level     (level),
        .Status    (status)
    );

    always #5 clk = ~clk;

    // reference model: queue of accepted commands plus sticky overflow
    logic [31:0] exp_q[$];
    bit          m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit pop_m;
        if (!rst_n) begin
            exp_q.delete();
            m_ovf = 1'b0;
        end else if (clr) begin
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            pop_m = (exp_q.size() != 0) && cif.cmd_ready;
            if (trig && exp_q.size() == DEPTH && !pop_m) begin
                m_ovf = 1'b1;
                if (pop_m) void'(exp_q.pop_front());
            end else begin
                if (pop_m) void'(exp_q.pop_front());
                if (trig)  exp_q.push_back({img, red, green, blue});
            end
        end
    end

    function automatic logic [7:0] exp_status();
        int n = exp_q.size();
        logic [3:0] sat = (n > 15) ? 4'hF : 4'(n);
        return {sat, (n >= DEPTH/2), m_ovf, (n == DEPTH), (n == 0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: compares DUT outputs against the model away from the clock edge
    always @(negedge clk) begin
        check("cmd_valid", 32'(cif.cmd_valid), 32'(exp_q.size() != 0));
        check("level", 32'(level), 32'(exp_q.size()));
        check("status", 32'(status), 32'(exp_status()));
        if (cif.cmd_valid && exp_q.size() != 0)
            check("head", {cif.cmd_img, cif.cmd_rgb}, exp_q[0]);
    end

    task automatic step(input bit t, input bit rdy, input bit c,
                        input logic [7:0] i, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b);
        @(posedge clk);
        #1;
        trig = t; cif.cmd_ready = rdy; clr = c;
        img = i; red = r; green = g; blue = b;
    endtask

    task automatic idle(input int unsigned n, input bit rdy);
        for (int unsigned k = 0; k < n; k++) step(1'b0, rdy, 1'b0, img, red, green, blue);
    endtask

    task automatic settle();
        step(1'b0, 1'b0, 1'b0, img, red, green, blue);
        @(negedge clk);
    endtask

    initial begin
        cif.cmd_ready = 1'b0;
        #12 rst_n = 1'b1;

        // initial state
        @(negedge clk);
        check("reset_status", 32'(status), 32'h01);
        check("reset_valid", 32'(cif.cmd_valid), 32'h0);

        // single command
        step(1'b1, 1'b0, 1'b0, 8'h07, 8'h12, 8'h34, 8'h56);
        settle();
        check("single_rgb", 32'(cif.cmd_rgb), 32'h123456);
        check("single_img", 32'(cif.cmd_img), 32'h07);
        check("single_status", 32'(status), 32'h10);
        idle(1, 1'b1);
        settle();
        check("single_drained", 32'(status), 32'h01);

        // fill to full, then overflow, then drain
        for (int unsigned k = 0; k < DEPTH; k++)
            step(1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 8'(k));
        settle();
        check("full_status", 32'(status), 32'hFA);
        step(1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 8'hAA);
        settle();
        check("ovf_status", 32'(status), 32'hFE);
        idle(DEPTH, 1'b1);
        settle();
        check("drained_ovf", 32'(status), 32'h05);

        // push and pop together while full
        clr = 1'b1; idle(1, 1'b0); clr = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++)
            step(1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 8'h00, 8'(k));
        step(1'b1, 1'b1, 1'b0, 8'h02, 8'h00, 8'h00, 8'h99);
        settle();
        check("full_pushpop", 32'(status), 32'hFA);
        idle(DEPTH - 1, 1'b1);
        settle();
        check("last_is_99", 32'(cif.cmd_rgb), 32'h000099);
        idle(1, 1'b1);

        // clear beats a simultaneous trigger, with 5 stored and overflow set
        for (int unsigned k = 0; k < DEPTH + 1; k++)
            step(1'b1, 1'b0, 1'b0, 8'h03, 8'h11, 8'h22, 8'(k));
        idle(DEPTH - 5, 1'b1);
        settle();
        check("pre_clear", 32'(status), 32'h54);
        step(1'b1, 1'b0, 1'b1, 8'h03, 8'h11, 8'h22, 8'h77);
        settle();
        check("clear_status", 32'(status), 32'h01);
        check("clear_level", 32'(level), 32'h0);

        // asynchronous reset with 3 entries stored
        for (int unsigned k = 0; k < 3; k++)
            step(1'b1, 1'b0, 1'b0, 8'h04, 8'h00, 8'h00, 8'(k));
        step(1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h00, 8'h00);
        #2 rst_n = 1'b0;
        #1 check("async_valid", 32'(cif.cmd_valid), 32'h0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_status", 32'(status), 32'h01);

        // randomised traffic
        for (int unsigned k = 0; k < 3000; k++)
            step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 127) == 0),
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        idle(DEPTH + 2, 1'b1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
